// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, default framing constants and the parity rule.
// The transmitter uses the same parity rule, so both ends of the link agree on it.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 27;
  localparam int UART_DATA_BITS    = 8;

  typedef logic [2:0] uart_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Byte-level handshake between the UART receiver and its consumer.
interface uart_rx_frame_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      parity_err;
  logic                      frame_err;
  logic                      overrun;

  modport master (output rx_data, rx_valid, parity_err, frame_err, overrun, input rx_ready);
  modport slave  (input rx_data, rx_valid, parity_err, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 so an idle-high line never
// looks like an edge coming out of reset.
module uart_rx_sync (
  input  logic clk_3125,
  input  logic rst_n,
  input  logic d_async,
  output logic q_sync
);

  logic meta;

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      q_sync <= 1'b1;
    end else begin
      meta   <= d_async;
      q_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 8E1 frames, centre-sampled, delivered through a one-byte valid/ready
// holding register with parity, framing and overrun status.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
  input  logic               clk_3125,
  input  logic               rst_n,
  input  logic               rx,
  uart_rx_frame_if.master    rx_bus
);

  localparam logic [4:0] CNT_LAST = 5'(CLKS_PER_BIT - 1);
  localparam logic [4:0] CNT_HALF = 5'(HALF_BIT);

  logic                      rx_s;
  uart_state_t               state;
  logic [4:0]                cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      par_bit;

  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      perr_q;
  logic                      ferr_q;
  logic                      ovr_q;

  uart_rx_sync u_sync (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .d_async  (rx),
    .q_sync   (rx_s)
  );

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (valid_q && rx_bus.rx_ready) begin
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= ST_PARITY;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
              // Loading while the old byte is being accepted keeps rx_valid high with no gap.
              if (!valid_q || rx_bus.rx_ready) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
                perr_q  <= par_bit ^ even_parity(shreg);
              end else begin
                ovr_q <= 1'b1;
              end
            end else begin
              ferr_q <= 1'b1;
              state  <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  assign rx_bus.rx_data    = data_q;
  assign rx_bus.rx_valid   = valid_q;
  assign rx_bus.parity_err = perr_q;
  assign rx_bus.frame_err  = ferr_q;
  assign rx_bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames are driven bit by bit on the falling edge and
// outputs are captured around the stop-bit centre sample.
module tb_uart_rx_frame;

  logic clk_3125;
  logic rst_n;
  logic rx;

  uart_rx_frame_if bus ();

  uart_rx_frame dut (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_bus   (bus)
  );

  initial begin
    clk_3125 = 1'b0;
    forever #160 clk_3125 = ~clk_3125;
  end

  int checks = 0;
  int errors = 0;

  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int val_cnt = 0;

  always @(negedge clk_3125) begin
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.overrun   === 1'b1) ov_cnt++;
    if (bus.rx_valid  === 1'b1) val_cnt++;
  end

  logic       cap_pre;
  logic       cap_valid;
  logic [7:0] cap_data;
  logic       cap_perr;
  logic       cap_ferr;
  logic       cap_ovr;
  logic       cap_post;

  int fe0, ov0, val0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a full frame starting at the current falling edge; returns at the end of the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    rx = 1'b0;
    repeat (27) @(negedge clk_3125);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (27) @(negedge clk_3125);
    end
    rx = par;
    repeat (27) @(negedge clk_3125);
    rx = stp;
    repeat (16) @(negedge clk_3125);
    cap_pre = bus.rx_valid;
    @(negedge clk_3125);
    cap_valid = bus.rx_valid;
    cap_data  = bus.rx_data;
    cap_perr  = bus.parity_err;
    cap_ferr  = bus.frame_err;
    cap_ovr   = bus.overrun;
    @(negedge clk_3125);
    cap_post = bus.rx_valid;
    repeat (9) @(negedge clk_3125);
  endtask

  initial begin
    rst_n        = 1'b0;
    rx           = 1'b1;
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk_3125);
    check("reset_rx_data",    32'(bus.rx_data),    32'h0);
    check("reset_rx_valid",   32'(bus.rx_valid),   32'h0);
    check("reset_parity_err", 32'(bus.parity_err), 32'h0);
    check("reset_frame_err",  32'(bus.frame_err),  32'h0);
    check("reset_overrun",    32'(bus.overrun),    32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_3125);

    // 0xA5 with correct parity, consumer always ready
    bus.rx_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1);
    check("a5_valid_before_centre", 32'(cap_pre),   32'h0);
    check("a5_valid",               32'(cap_valid), 32'h1);
    check("a5_data",                32'(cap_data),  32'hA5);
    check("a5_parity_err",          32'(cap_perr),  32'h0);
    check("a5_valid_one_cycle",     32'(cap_post),  32'h0);

    // 0x01 with parity forced wrong
    send_frame(8'h01, 1'b0, 1'b1);
    check("p01_valid",      32'(cap_valid), 32'h1);
    check("p01_data",       32'(cap_data),  32'h01);
    check("p01_parity_err", 32'(cap_perr),  32'h1);
    check("p01_frame_err",  32'(cap_ferr),  32'h0);

    // 0x3C with low stop bit, then a long break
    fe0 = fe_cnt; val0 = val_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    check("f3c_frame_err", 32'(cap_ferr),  32'h1);
    check("f3c_valid",     32'(cap_valid), 32'h0);
    repeat (1000) @(negedge clk_3125);
    check("break_one_frame_err", 32'(fe_cnt - fe0),    32'd1);
    check("break_no_valid",      32'(val_cnt - val0),  32'd0);
    rx = 1'b1;
    repeat (10) @(negedge clk_3125);
    send_frame(8'h55, 1'b0, 1'b1);
    check("r55_valid",      32'(cap_valid), 32'h1);
    check("r55_data",       32'(cap_data),  32'h55);
    check("r55_parity_err", 32'(cap_perr),  32'h0);

    // Overrun: two frames back-to-back with no consumer
    bus.rx_ready = 1'b0;
    repeat (5) @(negedge clk_3125);
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b0, 1'b1);
    check("o11_valid", 32'(cap_valid), 32'h1);
    check("o11_data",  32'(cap_data),  32'h11);
    send_frame(8'h22, 1'b0, 1'b1);
    check("o22_overrun_at_stop", 32'(cap_ovr),        32'h1);
    check("o22_data_kept",       32'(cap_data),       32'h11);
    check("o22_overrun_count",   32'(ov_cnt - ov0),   32'd1);
    check("o22_still_valid",     32'(bus.rx_valid),   32'h1);
    bus.rx_ready = 1'b1;
    @(negedge clk_3125);
    check("o_accept_clears_valid", 32'(bus.rx_valid), 32'h0);

    // Short low glitch in idle must not produce a byte or any flag
    bus.rx_ready = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt; val0 = val_cnt;
    rx = 1'b0;
    repeat (5) @(negedge clk_3125);
    rx = 1'b1;
    repeat (40) @(negedge clk_3125);
    check("glitch_no_frame_err", 32'(fe_cnt - fe0),   32'd0);
    check("glitch_no_overrun",   32'(ov_cnt - ov0),   32'd0);
    check("glitch_no_valid",     32'(val_cnt - val0), 32'd0);
    send_frame(8'hFF, 1'b0, 1'b1);
    check("gff_valid",      32'(cap_valid), 32'h1);
    check("gff_data",       32'(cap_data),  32'hFF);
    check("gff_parity_err", 32'(cap_perr),  32'h0);

    // Reset in the middle of data bit 4 of 0x96 while 0xFF is still held
    rx = 1'b0;
    repeat (27) @(negedge clk_3125);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 1 || i == 2) ? 1'b1 : 1'b0;
      repeat (27) @(negedge clk_3125);
    end
    rx = 1'b1;
    repeat (13) @(negedge clk_3125);
    rst_n = 1'b0;
    #1;
    check("midrst_valid",      32'(bus.rx_valid),   32'h0);
    check("midrst_data",       32'(bus.rx_data),    32'h0);
    check("midrst_parity_err", 32'(bus.parity_err), 32'h0);
    repeat (3) @(negedge clk_3125);
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (10) @(negedge clk_3125);
    bus.rx_ready = 1'b1;
    send_frame(8'h96, 1'b0, 1'b1);
    check("r96_valid",      32'(cap_valid), 32'h1);
    check("r96_data",       32'(cap_data),  32'h96);
    check("r96_parity_err", 32'(cap_perr),  32'h0);
    check("r96_frame_err",  32'(cap_ferr),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
